fifo_fill_reader: RTL and testbench
===================================

Name: fifo_fill_reader

Overview:
- Downstream stage of the fill-FIFO FSM in hdmi_out.
- Consumes its one-cycle go_fill_fifo pulse and line/frame address ddr_addr_to_read.
- Issues a fixed number of DDR burst reads through a request/acknowledge memory port and pushes returned pixel words into the pixel FIFO feeding the HDMI timing generator.
- Reports busy/done and sticky error flags to user slave registers.

Parameters:
- BURST_LEN, 16: 32-bit words per DDR burst (power of two, 2..64).
- BURSTS_PER_FILL, 2: bursts issued per go pulse (one half-FIFO fill).
- BYTES_PER_WORD, 4: address increment per word.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- go_fill_fifo  in  1  one-cycle start pulse from the fill FSM.
- ddr_addr_to_read  in  32  byte start address; sampled with go_fill_fifo.
- rd_req  out  1  burst read request; held until acknowledged.
- rd_addr  out  32  burst byte address; stable while rd_req is high.
- rd_ack  in  1  memory accepted the request (sampled when rd_req is high).
- rd_data  in  32  returned read word.
- rd_data_valid  in  1  rd_data valid this cycle; no backpressure possible.
- fifo_wr_en  out  1  pixel FIFO write strobe.
- fifo_wr_data  out  32  pixel FIFO write data.
- fifo_full  in  1  pixel FIFO cannot accept a write this cycle.
- busy  out  1  high whenever state is not IDLE.
- fill_done  out  1  one-cycle pulse when the last word of a fill is received.
- overflow_err  out  1  sticky: a word arrived while fifo_full was high.
- missed_go_err  out  1  sticky: go_fill_fifo arrived while busy.
- clear_err  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, rd_addr 0.
- States: IDLE, REQ, DATA.
  - IDLE: on go_fill_fifo, latch ddr_addr_to_read with bits [1:0] forced to 0 into rd_addr, clear burst_cnt, and go to REQ. rd_req is high in the cycle after go (one-cycle latency).
  - REQ: rd_req=1. On rd_ack=1 at a clock edge: rd_req<=0, word_cnt<=0, go to DATA. rd_addr is unchanged while waiting, with no timeout.
  - DATA: each rd_data_valid increments word_cnt. On the edge accepting word BURST_LEN-1:
    - If burst_cnt < BURSTS_PER_FILL-1: rd_addr += BURST_LEN*BYTES_PER_WORD (modulo 2^32, wraps silently), burst_cnt++, go to REQ (rd_req high next cycle).
    - Else: fill_done<=1 for one cycle, go to IDLE.
- rd_data_valid in IDLE or REQ is ignored (stale data after reset is discarded).
- FIFO write path is registered, one-cycle latency:
  - rd_data_valid in DATA with fifo_full=0: next cycle fifo_wr_en=1, fifo_wr_data=rd_data.
  - With fifo_full=1: no write, overflow_err<=1, and the word is still counted so the burst completes.
- go_fill_fifo when busy=1: ignored, missed_go_err<=1. This includes the cycle fill_done is asserted (state is still DATA on that edge).
- clear_err=1 clears both sticky flags. If an error event occurs in the same cycle, set wins.
- Reset mid-operation: immediate return to IDLE; rd_req, fifo_wr_en and busy drop asynchronously.
- Widths: word_cnt is clog2(BURST_LEN)+1 bits; burst_cnt is clog2(BURSTS_PER_FILL)+1 bits.

Decomposition:
- Shared package hdmi_out_pkg holds:
  - state encoding (IDLE, REQ, DATA);
  - BYTES_PER_WORD;
  - the default burst constants, shared with fill_fifo_fsm so the half-FIFO size matches.
- Single module. No sub-module is warranted; counters and the FSM are small.

Test Plan:
- go with addr 0x80000000, rd_ack 2 cycles after rd_req, 16 valid words per burst -> rd_addr 0x80000000 then 0x80000040; 32 fifo_wr_en pulses with matching data; fill_done pulses one cycle after word 32 is accepted; busy then falls.
- rd_ack held low for 10 cycles -> rd_req and rd_addr stay stable for all 10 cycles; no fifo writes occur.
- go with addr 0xFFFFFFC3 -> first rd_addr 0xFFFFFFC0, second rd_addr 0x00000000; fill completes normally.
- fifo_full high for data word 5 only -> 31 writes, overflow_err=1, fill_done still pulses; clear_err -> overflow_err=0.
- go while in DATA, and go in the fill_done cycle -> both ignored, missed_go_err=1, exactly one fill performed.
- reset asserted mid-DATA after 7 words, 3 more rd_data_valid words arrive after release -> outputs 0, no writes; next go at 0x80004000 performs a clean 32-word fill.

Source files
------------

// File: rtl/hdmi_out_pkg.sv
// Shared definitions for the hdmi_out fill path: state encoding and burst geometry.
// fill_fifo_fsm uses the same burst defaults, so its half-FIFO size matches what this reader fetches.
package hdmi_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fill_state_t;

    localparam int DEFAULT_BURST_LEN       = 16;
    localparam int DEFAULT_BURSTS_PER_FILL = 2;
    localparam int BYTES_PER_WORD          = 4;

endpackage

// File: rtl/fifo_fill_reader_if.sv
// Memory read port plus pixel FIFO write port seen by fifo_fill_reader.
// The master modport is the reader side. The slave modport is the memory/FIFO side.
interface fifo_fill_reader_if;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full;

    modport master (
        output rd_req, rd_addr, fifo_wr_en, fifo_wr_data,
        input  rd_ack, rd_data, rd_data_valid, fifo_full
    );

    modport slave (
        input  rd_req, rd_addr, fifo_wr_en, fifo_wr_data,
        output rd_ack, rd_data, rd_data_valid, fifo_full
    );

endinterface

// File: rtl/fifo_fill_reader.sv
// Fetches BURSTS_PER_FILL DDR bursts per go pulse and streams the returned words into the pixel FIFO.
// Status flags: busy, a fill_done pulse, and sticky overflow/missed-go errors.
module fifo_fill_reader
    import hdmi_out_pkg::*;
#(
    parameter int BURST_LEN       = DEFAULT_BURST_LEN,
    parameter int BURSTS_PER_FILL = DEFAULT_BURSTS_PER_FILL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go_fill_fifo,
    input  logic [31:0]        ddr_addr_to_read,
    input  logic               clear_err,
    fifo_fill_reader_if.master bus,
    output logic               busy,
    output logic               fill_done,
    output logic               overflow_err,
    output logic               missed_go_err
);

    localparam int WORD_CNT_W  = $clog2(BURST_LEN) + 1;
    localparam int BURST_CNT_W = $clog2(BURSTS_PER_FILL) + 1;
    localparam logic [WORD_CNT_W-1:0]  LAST_WORD    = WORD_CNT_W'(BURST_LEN - 1);
    localparam logic [BURST_CNT_W-1:0] LAST_BURST   = BURST_CNT_W'(BURSTS_PER_FILL - 1);
    localparam logic [31:0]            BURST_STRIDE = 32'(BURST_LEN * BYTES_PER_WORD);

    fill_state_t              r_state;
    logic                     r_rd_req;
    logic [31:0]              r_rd_addr;
    logic [WORD_CNT_W-1:0]    r_word_cnt;
    logic [BURST_CNT_W-1:0]   r_burst_cnt;
    logic                     r_fifo_wr_en;
    logic [31:0]              r_fifo_wr_data;
    logic                     r_fill_done;
    logic                     r_overflow_err;
    logic                     r_missed_go_err;

    logic                     w_busy;
    logic                     w_word_accept;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_word_accept = (r_state == ST_DATA) && bus.rd_data_valid;

    // Error updates come after the clear, so a same-cycle error event overrides clear_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_rd_req        <= 1'b0;
            r_rd_addr       <= 32'd0;
            r_word_cnt      <= '0;
            r_burst_cnt     <= '0;
            r_fifo_wr_en    <= 1'b0;
            r_fifo_wr_data  <= 32'd0;
            r_fill_done     <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_missed_go_err <= 1'b0;
        end else begin
            r_fifo_wr_en <= 1'b0;
            r_fill_done  <= 1'b0;

            if (clear_err) begin
                r_overflow_err  <= 1'b0;
                r_missed_go_err <= 1'b0;
            end
            if (go_fill_fifo && w_busy) begin
                r_missed_go_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (go_fill_fifo) begin
                        r_rd_addr   <= ddr_addr_to_read & ~32'h3;
                        r_burst_cnt <= '0;
                        r_rd_req    <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.rd_ack) begin
                        r_rd_req   <= 1'b0;
                        r_word_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_word_accept) begin
                        // A word that meets a full FIFO is dropped but still counted, so the burst completes.
                        if (bus.fifo_full) begin
                            r_overflow_err <= 1'b1;
                        end else begin
                            r_fifo_wr_en   <= 1'b1;
                            r_fifo_wr_data <= bus.rd_data;
                        end
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == LAST_WORD) begin
                            if (r_burst_cnt < LAST_BURST) begin
                                r_rd_addr   <= r_rd_addr + BURST_STRIDE;
                                r_burst_cnt <= r_burst_cnt + 1'b1;
                                r_rd_req    <= 1'b1;
                                r_state     <= ST_REQ;
                            end else begin
                                r_fill_done <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_rd_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req       = r_rd_req;
    assign bus.rd_addr      = r_rd_addr;
    assign bus.fifo_wr_en   = r_fifo_wr_en;
    assign bus.fifo_wr_data = r_fifo_wr_data;
    assign busy             = w_busy;
    assign fill_done        = r_fill_done;
    assign overflow_err     = r_overflow_err;
    assign missed_go_err    = r_missed_go_err;

endmodule

// File: tb/tb_fifo_fill_reader.sv
// Directed bench for fifo_fill_reader: drives the memory and FIFO side by hand and checks
// burst addresses, FIFO writes, done/busy timing and the sticky error flags.
module tb_fifo_fill_reader;

    logic        clk;
    logic        reset;
    logic        go_fill_fifo;
    logic [31:0] ddr_addr_to_read;
    logic        clear_err;
    logic        busy;
    logic        fill_done;
    logic        overflow_err;
    logic        missed_go_err;

    fifo_fill_reader_if bus ();

    fifo_fill_reader dut (
        .clk              (clk),
        .reset            (reset),
        .go_fill_fifo     (go_fill_fifo),
        .ddr_addr_to_read (ddr_addr_to_read),
        .clear_err        (clear_err),
        .bus              (bus.master),
        .busy             (busy),
        .fill_done        (fill_done),
        .overflow_err     (overflow_err),
        .missed_go_err    (missed_go_err)
    );

    int vectors;
    int miscompares;

    logic [31:0] wrData[$];
    logic [31:0] reqAddr[$];
    int          doneCnt;
    logic        prevReq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive monitor: collects FIFO writes, burst addresses and done pulses between clock edges.
    always @(negedge clk) begin
        if (bus.fifo_wr_en) wrData.push_back(bus.fifo_wr_data);
        if (bus.rd_req && !prevReq) reqAddr.push_back(bus.rd_addr);
        prevReq = bus.rd_req;
        if (fill_done) doneCnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_monitor();
        wrData.delete();
        reqAddr.delete();
        doneCnt = 0;
    endtask

    // Pulses go, then answers BURSTS of 16 words. Word k carries dataBase+k;
    // fifo_full is raised on word fullIdx, and go is pulsed again on word goIdx.
    task automatic run_fill(input logic [31:0] startAddr, input int ackDelay,
                            input int fullIdx, input int goIdx, input logic [31:0] dataBase,
                            output logic doneAtEnd, output logic busyAtEnd);
        int waitCnt;
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = startAddr;
        @(negedge clk);
        go_fill_fifo = 1'b0;
        doneAtEnd = 1'b0;
        busyAtEnd = 1'b1;
        for (int b = 0; b < 2; b++) begin
            waitCnt = 0;
            while (!bus.rd_req && waitCnt < 20) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!bus.rd_req) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rd_req_timeout: burst %0d request never seen, got 0 want 1", b);
                return;
            end
            repeat (ackDelay) @(negedge clk);
            bus.rd_ack = 1'b1;
            @(negedge clk);
            bus.rd_ack = 1'b0;
            for (int i = 0; i < 16; i++) begin
                bus.rd_data_valid = 1'b1;
                bus.rd_data       = dataBase + 32'(16 * b + i);
                bus.fifo_full     = ((16 * b + i) == fullIdx);
                go_fill_fifo      = ((16 * b + i) == goIdx);
                @(negedge clk);
            end
            bus.rd_data_valid = 1'b0;
            bus.fifo_full     = 1'b0;
            go_fill_fifo      = 1'b0;
        end
        doneAtEnd = fill_done;
        busyAtEnd = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.rd_req, bus.fifo_wr_en, busy, fill_done, overflow_err, missed_go_err} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want 000000",
                     {bus.rd_req, bus.fifo_wr_en, busy, fill_done, overflow_err, missed_go_err});
        end
        vectors++;
        if (bus.rd_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd_addr: got %h want 00000000", bus.rd_addr);
        end
        vectors++;
        if (bus.fifo_wr_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_wr_data: got %h want 00000000", bus.fifo_wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        logic d, b;
        clear_monitor();
        run_fill(32'h8000_0000, 2, -1, -1, 32'hA000_0000, d, b);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_done_pulse: got %b want 1", d);
        end
        vectors++;
        if (b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_busy_fall: got %b want 0", b);
        end
        @(negedge clk);
        vectors++;
        if (fill_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_done_one_cycle: got %b want 0", fill_done);
        end
        vectors++;
        if (reqAddr.size() !== 2 || reqAddr[0] !== 32'h8000_0000 || reqAddr[1] !== 32'h8000_0040) begin
            miscompares++;
            $display("[TB] FAIL basic_addrs: got n=%0d %h %h want n=2 80000000 80000040",
                     reqAddr.size(), reqAddr.size() > 0 ? reqAddr[0] : 32'hx,
                     reqAddr.size() > 1 ? reqAddr[1] : 32'hx);
        end
        vectors++;
        if (wrData.size() !== 32) begin
            miscompares++;
            $display("[TB] FAIL basic_write_count: got %0d want 32", wrData.size());
        end
        for (int k = 0; k < 32 && k < wrData.size(); k++) begin
            vectors++;
            if (wrData[k] !== 32'hA000_0000 + 32'(k)) begin
                miscompares++;
                $display("[TB] FAIL basic_data[%0d]: got %h want %h", k, wrData[k], 32'hA000_0000 + 32'(k));
            end
        end
        vectors++;
        if (doneCnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL basic_done_count: got %0d want 1", doneCnt);
        end
    endtask

    task automatic test_ack_stall();
        logic d, b;
        clear_monitor();
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h1234_5678;
        @(negedge clk);
        go_fill_fifo = 1'b0;
        // Stale valid data while waiting for the ack must be discarded.
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (bus.rd_req !== 1'b1 || bus.rd_addr !== 32'h1234_5678) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got req=%b addr=%h want req=1 addr=12345678",
                         c, bus.rd_req, bus.rd_addr);
            end
            @(negedge clk);
        end
        bus.rd_data_valid = 1'b0;
        vectors++;
        if (wrData.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL stall_no_writes: got %0d want 0", wrData.size());
        end
        // Finish this fill: run_fill's go is ignored because the reader is busy, so clear that flag after.
        run_fill(32'h0, 0, -1, -1, 32'h0, d, b);
        @(negedge clk);
        vectors++;
        if (reqAddr.size() !== 2 || reqAddr[1] !== 32'h1234_56B8) begin
            miscompares++;
            $display("[TB] FAIL stall_second_addr: got n=%0d %h want n=2 123456b8",
                     reqAddr.size(), reqAddr.size() > 1 ? reqAddr[1] : 32'hx);
        end
        vectors++;
        if (wrData.size() !== 32 || doneCnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL stall_fill_complete: got writes=%0d done=%0d want 32 1", wrData.size(), doneCnt);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic d, b;
        clear_monitor();
        run_fill(32'hFFFF_FFC3, 1, -1, -1, 32'h0000_1000, d, b);
        @(negedge clk);
        vectors++;
        if (reqAddr.size() !== 2 || reqAddr[0] !== 32'hFFFF_FFC0 || reqAddr[1] !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL wrap_addrs: got n=%0d %h %h want n=2 ffffffc0 00000000",
                     reqAddr.size(), reqAddr.size() > 0 ? reqAddr[0] : 32'hx,
                     reqAddr.size() > 1 ? reqAddr[1] : 32'hx);
        end
        vectors++;
        if (wrData.size() !== 32 || doneCnt !== 1 || d !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_fill: got writes=%0d done=%0d pulse=%b want 32 1 1", wrData.size(), doneCnt, d);
        end
    endtask

    task automatic test_overflow();
        logic d, b;
        int k;
        clear_monitor();
        run_fill(32'h8000_0100, 0, 5, -1, 32'hB000_0000, d, b);
        @(negedge clk);
        vectors++;
        if (wrData.size() !== 31) begin
            miscompares++;
            $display("[TB] FAIL ovf_write_count: got %0d want 31", wrData.size());
        end
        k = 0;
        for (int w = 0; w < 32; w++) begin
            if (w == 5) continue;
            if (k < wrData.size()) begin
                vectors++;
                if (wrData[k] !== 32'hB000_0000 + 32'(w)) begin
                    miscompares++;
                    $display("[TB] FAIL ovf_data[%0d]: got %h want %h", k, wrData[k], 32'hB000_0000 + 32'(w));
                end
            end
            k++;
        end
        vectors++;
        if (overflow_err !== 1'b1 || doneCnt !== 1 || missed_go_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_flags: got ovf=%b done=%0d missed=%b want 1 1 0", overflow_err, doneCnt, missed_go_err);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear: got %b want 0", overflow_err);
        end
    endtask

    task automatic test_missed_go();
        logic d, b;
        clear_monitor();
        run_fill(32'h8000_0200, 0, -1, 3, 32'hC000_0000, d, b);
        vectors++;
        if (d !== 1'b1 || b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL missed_done_busy: got done=%b busy=%b want 1 0", d, b);
        end
        // Rerun with go landing on the last word's edge; the go that fell mid-burst alone already sets the flag.
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        vectors++;
        if (missed_go_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL missed_clear: got %b want 0", missed_go_err);
        end
        clear_monitor();
        run_fill(32'h8000_0300, 0, -1, 31, 32'hC100_0000, d, b);
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || bus.rd_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL missed_no_restart: got busy=%b req=%b want 0 0", busy, bus.rd_req);
            end
        end
        vectors++;
        if (missed_go_err !== 1'b1 || doneCnt !== 1 || wrData.size() !== 32 || reqAddr.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL missed_last_edge: got missed=%b done=%0d writes=%0d reqs=%0d want 1 1 32 2",
                     missed_go_err, doneCnt, wrData.size(), reqAddr.size());
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic d, b;
        go_fill_fifo     = 1'b1;
        ddr_addr_to_read = 32'h8000_2000;
        @(negedge clk);
        go_fill_fifo = 1'b0;
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = 32'hD000_0000 + 32'(i);
            @(negedge clk);
        end
        bus.rd_data_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.rd_req, bus.fifo_wr_en, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_async: got req/wr/busy=%b want 000", {bus.rd_req, bus.fifo_wr_en, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_monitor();
        for (int i = 0; i < 3; i++) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = 32'hE000_0000 + 32'(i);
            @(negedge clk);
        end
        bus.rd_data_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (wrData.size() !== 0 || busy !== 1'b0 || bus.rd_addr !== 32'h0 || fill_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_stale: got writes=%0d busy=%b addr=%h done=%b want 0 0 00000000 0",
                     wrData.size(), busy, bus.rd_addr, fill_done);
        end
        clear_monitor();
        run_fill(32'h8000_4000, 1, -1, -1, 32'hF000_0000, d, b);
        @(negedge clk);
        vectors++;
        if (reqAddr.size() !== 2 || reqAddr[0] !== 32'h8000_4000 || reqAddr[1] !== 32'h8000_4040) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_addrs: got n=%0d %h %h want n=2 80004000 80004040",
                     reqAddr.size(), reqAddr.size() > 0 ? reqAddr[0] : 32'hx,
                     reqAddr.size() > 1 ? reqAddr[1] : 32'hx);
        end
        vectors++;
        if (wrData.size() !== 32 || doneCnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_refill: got writes=%0d done=%0d want 32 1", wrData.size(), doneCnt);
        end
        for (int k = 0; k < 32 && k < wrData.size(); k += 8) begin
            vectors++;
            if (wrData[k] !== 32'hF000_0000 + 32'(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_data[%0d]: got %h want %h", k, wrData[k], 32'hF000_0000 + 32'(k));
            end
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        doneCnt           = 0;
        prevReq           = 1'b0;
        reset             = 1'b1;
        go_fill_fifo      = 1'b0;
        ddr_addr_to_read  = 32'h0;
        clear_err         = 1'b0;
        bus.rd_ack        = 1'b0;
        bus.rd_data       = 32'h0;
        bus.rd_data_valid = 1'b0;
        bus.fifo_full     = 1'b0;

        $display("[TB] starting fifo_fill_reader tests");
        test_reset();
        test_basic_fill();
        test_ack_stall();
        test_addr_wrap();
        test_overflow();
        test_missed_go();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
